ps2_famicom_pad: RTL and testbench

// - Emulates the Famicom serial game controller that the Gigatron shell polls on

---
 rtl/gigatron_pad_pkg.sv | 44 ++++
 rtl/sync_edge.sv | 37 +++
 rtl/ps2_famicom_pad.sv | 102 ++++++++++
 tb/tb_ps2_famicom_pad.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gigatron_pad_pkg.sv
// rtl/gigatron_pad_pkg.sv - shared types, button indices and scancodes for the Famicom pad emulator
//
// Purpose: button bit positions (shift order), PS/2 scancodes that drive them,
//          and the joystick-to-pad remap helper.
// Ports:   none (package).
package gigatron_pad_pkg;

  typedef logic [7:0] pad_t;

  // Bit position of each button in the pad vector; also the serial shift order.
  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;

  // Letter keys are plain codes; arrow keys arrive with the E0 prefix.
  localparam logic [7:0] SC_X     = 8'h22;
  localparam logic [7:0] SC_Z     = 8'h1A;
  localparam logic [7:0] SC_TAB   = 8'h0D;
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;

  // Joystick word is [0]R [1]L [2]D [3]U [4]A [5]B [6]Select [7]Start.
  function automatic pad_t joy_remap(input logic [7:0] joy);
    pad_t r;
    r[BTN_A]      = joy[4];
    r[BTN_B]      = joy[5];
    r[BTN_SELECT] = joy[6];
    r[BTN_START]  = joy[7];
    r[BTN_UP]     = joy[3];
    r[BTN_DOWN]   = joy[2];
    r[BTN_LEFT]   = joy[1];
    r[BTN_RIGHT]  = joy[0];
    return r;
  endfunction

endpackage

// File: rtl/sync_edge.sv
// rtl/sync_edge.sv - multi-flop synchronizer with rising-edge detect
//
// Purpose: brings an asynchronous level into clk and flags its rising edge.
// Ports:   clk, reset (sync, active-high), d (async in),
//          level (synchronized d), rise (one-cycle pulse on level 0->1).
module sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic level,
  output logic rise
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
    prev_d = sync_q[STAGES-1];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign level = sync_q[STAGES-1];
  assign rise  = sync_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/ps2_famicom_pad.sv
// rtl/ps2_famicom_pad.sv - Famicom serial pad emulator fed by PS/2 keys and a joystick word
//
// Purpose: decodes PS/2 key events into a held-button vector, merges it with the
//          joystick, and serves it on the Famicom latch/pulse/data protocol.
// Ports:   clk_sys, reset (sync, active-high), ps2_key[10:0], joystick[7:0],
//          famicom_latch / famicom_pulse (async), famicom_data (active-low bit),
//          pad_state[7:0] (registered merged pressed vector).
module ps2_famicom_pad
  import gigatron_pad_pkg::*;
#(
  parameter int   SYNC_STAGES = 2,
  parameter logic FILL_BIT    = 1'b1
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic [10:0] ps2_key,
  input  logic [7:0]  joystick,
  input  logic        famicom_latch,
  input  logic        famicom_pulse,
  output logic        famicom_data,
  output logic [7:0]  pad_state
);

  logic latch_s, latch_rise;
  logic pulse_s, pulse_rise;

  sync_edge #(.STAGES(SYNC_STAGES)) u_latch_sync (
    .clk   (clk_sys),
    .reset (reset),
    .d     (famicom_latch),
    .level (latch_s),
    .rise  (latch_rise)
  );

  sync_edge #(.STAGES(SYNC_STAGES)) u_pulse_sync (
    .clk   (clk_sys),
    .reset (reset),
    .d     (famicom_pulse),
    .level (pulse_s),
    .rise  (pulse_rise)
  );

  pad_t key_state_q, key_state_d;
  logic ev_q, ev_d;
  pad_t sr_q, sr_d;
  pad_t pad_state_q, pad_state_d;
  pad_t pressed;

  // Each toggle of ps2_key[10] is one event; only the eight mapped keys
  // (with the matching extended flag) touch key_state.
  always_comb begin
    key_state_d = key_state_q;
    ev_d        = ps2_key[10];
    if (ps2_key[10] != ev_q) begin
      case ({ps2_key[8], ps2_key[7:0]})
        {1'b0, SC_X}:     key_state_d[BTN_A]      = ps2_key[9];
        {1'b0, SC_Z}:     key_state_d[BTN_B]      = ps2_key[9];
        {1'b0, SC_TAB}:   key_state_d[BTN_SELECT] = ps2_key[9];
        {1'b0, SC_ENTER}: key_state_d[BTN_START]  = ps2_key[9];
        {1'b1, SC_UP}:    key_state_d[BTN_UP]     = ps2_key[9];
        {1'b1, SC_DOWN}:  key_state_d[BTN_DOWN]   = ps2_key[9];
        {1'b1, SC_LEFT}:  key_state_d[BTN_LEFT]   = ps2_key[9];
        {1'b1, SC_RIGHT}: key_state_d[BTN_RIGHT]  = ps2_key[9];
        default: ;
      endcase
    end
  end

  // Built from the registered key_state, so a reload coinciding with a key
  // event sees the pre-event buttons.
  assign pressed = key_state_q | joy_remap(joystick);

  // Latch level holds the register in reload; a pulse edge during latch is
  // therefore swallowed.
  always_comb begin
    pad_state_d = pressed;
    sr_d        = sr_q;
    if (latch_s) begin
      sr_d = ~pressed;
    end else if (pulse_rise) begin
      sr_d = {FILL_BIT, sr_q[7:1]};
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      key_state_q <= '0;
      ev_q        <= ps2_key[10];
      sr_q        <= 8'hFF;
      pad_state_q <= '0;
    end else begin
      key_state_q <= key_state_d;
      ev_q        <= ev_d;
      sr_q        <= sr_d;
      pad_state_q <= pad_state_d;
    end
  end

  assign famicom_data = sr_q[0];
  assign pad_state    = pad_state_q;

endmodule

// File: tb/tb_ps2_famicom_pad.sv
// tb/tb_ps2_famicom_pad.sv - scoreboard bench for ps2_famicom_pad against a button-level model
module tb_ps2_famicom_pad;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic [10:0] ps2_key;
  logic [7:0]  joystick;
  logic        famicom_latch;
  logic        famicom_pulse;
  logic        famicom_data;
  logic [7:0]  pad_state;

  ps2_famicom_pad #(.SYNC_STAGES(2), .FILL_BIT(1'b1)) dut (
    .clk_sys       (clk_sys),
    .reset         (reset),
    .ps2_key       (ps2_key),
    .joystick      (joystick),
    .famicom_latch (famicom_latch),
    .famicom_pulse (famicom_pulse),
    .famicom_data  (famicom_data),
    .pad_state     (pad_state)
  );

  always #5 clk_sys = ~clk_sys;

  int tests = 0;
  int fails = 0;

  typedef struct {
    bit         is_pad;
    logic [7:0] exp;
    string      name;
  } chk_t;

  chk_t sb[$];
  logic strobe = 1'b0;

  // Reference model: which buttons are held from the keyboard, and which
  // {extended, scancode} and joystick bit belong to each button.
  bit         key_dn[8];
  logic [8:0] btn_code[8];
  int         joy_bit[8];

  initial begin
    btn_code = '{9'h022, 9'h01A, 9'h00D, 9'h05A, 9'h175, 9'h172, 9'h16B, 9'h174};
    joy_bit  = '{4, 5, 6, 7, 3, 2, 1, 0};
  end

  function automatic int btn_of(input logic ext, input logic [7:0] code);
    for (int i = 0; i < 8; i++)
      if (btn_code[i] == {ext, code}) return i;
    return -1;
  endfunction

  function automatic logic [7:0] model_pad();
    logic [7:0] p;
    for (int i = 0; i < 8; i++) p[i] = key_dn[i] | joystick[joy_bit[i]];
    return p;
  endfunction

  // Monitor: whenever stimulus raises strobe, pop one expectation and compare.
  always @(negedge clk_sys) begin
    if (strobe) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL scoreboard_empty: strobe with no expectation");
      end else begin
        chk_t c;
        logic [7:0] act;
        c   = sb.pop_front();
        act = c.is_pad ? pad_state : {7'b0, famicom_data};
        tests++;
        if (act !== c.exp) begin
          fails++;
          $display("FAIL %s: got %02h expected %02h", c.name, act, c.exp);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic expect_item(input bit is_pad, input logic [7:0] e, input string nm);
    sb.push_back('{is_pad, e, nm});
    strobe = 1'b1;
    tick(1);
    strobe = 1'b0;
  endtask

  task automatic expect_data(input logic b, input string nm);
    expect_item(1'b0, {7'b0, b}, nm);
  endtask

  task automatic key_event(input logic ext, input logic [7:0] code, input logic press);
    int idx;
    ps2_key = {~ps2_key[10], press, ext, code};
    idx = btn_of(ext, code);
    if (idx >= 0) key_dn[idx] = press;
    tick(3);
  endtask

  task automatic do_reset(input bit toggle_key);
    reset = 1'b1;
    tick(1);
    if (toggle_key) ps2_key = {~ps2_key[10], 1'b1, 1'b0, 8'h22};
    tick(3);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) key_dn[i] = 1'b0;
    tick(2);
  endtask

  // Full frame: latch, then 9 pulses; bits past the eighth must be the fill.
  task automatic frame(input string nm);
    logic [7:0] p;
    p = model_pad();
    famicom_latch = 1'b1;
    tick(6);
    expect_data(~p[0], $sformatf("%s_bit0", nm));
    famicom_latch = 1'b0;
    tick(6);
    for (int k = 1; k <= 9; k++) begin
      famicom_pulse = 1'b1;
      tick(6);
      expect_data((k < 8) ? ~p[k] : 1'b1, $sformatf("%s_bit%0d", nm, k));
      famicom_pulse = 1'b0;
      tick(6);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] p;
    reset = 1'b1; ps2_key = '0; joystick = '0;
    famicom_latch = 1'b0; famicom_pulse = 1'b0;
    for (int i = 0; i < 8; i++) key_dn[i] = 1'b0;
    do_reset(1'b0);
    expect_item(1'b1, 8'h00, "reset_pad");
    expect_data(1'b1, "reset_data");
    frame("idle");

    key_event(1'b0, 8'h22, 1'b1);
    expect_item(1'b1, 8'h01, "x_pad");
    frame("x_held");
    key_event(1'b0, 8'h22, 1'b0);
    frame("x_rel");

    key_event(1'b1, 8'h74, 1'b1);
    frame("right");
    key_event(1'b1, 8'h74, 1'b0);
    key_event(1'b0, 8'h74, 1'b1);
    expect_item(1'b1, 8'h00, "plain74_pad");
    frame("plain74");

    key_event(1'b0, 8'h1A, 1'b1);
    joystick = 8'h88;
    tick(3);
    expect_item(1'b1, 8'h1A, "joy_z_pad");
    frame("joy_z");
    joystick = 8'h00;
    key_event(1'b0, 8'h1A, 1'b0);

    for (int r = 0; r < 12; r++) begin
      int n;
      n = $urandom_range(1, 3);
      for (int e = 0; e < n; e++) begin
        if ($urandom_range(0, 3) == 0) begin
          key_event(1'($urandom), 8'($urandom), 1'($urandom));
        end else begin
          logic [8:0] bc;
          bc = btn_code[$urandom_range(0, 7)];
          key_event(bc[8], bc[7:0], 1'($urandom));
        end
      end
      joystick = 8'($urandom);
      tick(3);
      expect_item(1'b1, model_pad(), $sformatf("rand%0d_pad", r));
      frame($sformatf("rand%0d", r));
    end

    joystick = 8'h00;
    for (int i = 0; i < 8; i++) key_event(btn_code[i][8], btn_code[i][7:0], 1'b0);
    key_event(1'b0, 8'h22, 1'b1);
    p = model_pad();
    famicom_latch = 1'b1;
    tick(6);
    famicom_pulse = 1'b1;
    tick(6);
    expect_data(~p[0], "pulse_in_latch");
    famicom_pulse = 1'b0;
    tick(2);
    famicom_latch = 1'b0;
    tick(6);
    expect_data(~p[0], "after_latch");
    famicom_latch = 1'b1;
    famicom_pulse = 1'b1;
    tick(6);
    expect_data(~p[0], "simul_rise");
    famicom_latch = 1'b0;
    tick(6);
    expect_data(~p[0], "simul_hold");
    famicom_pulse = 1'b0;
    tick(6);
    frame("after_overlap");

    joystick = 8'h21;
    key_event(1'b1, 8'h6B, 1'b1);
    p = model_pad();
    famicom_latch = 1'b1;
    tick(6);
    famicom_latch = 1'b0;
    tick(6);
    for (int k = 1; k <= 3; k++) begin
      famicom_pulse = 1'b1;
      tick(6);
      famicom_pulse = 1'b0;
      tick(6);
    end
    expect_data(~p[3], "mid_bit3");
    do_reset(1'b0);
    expect_data(1'b1, "mid_reset_data");
    expect_item(1'b1, model_pad(), "mid_reset_pad");
    frame("after_reset");

    joystick = 8'h00;
    do_reset(1'b1);
    tick(3);
    expect_item(1'b1, 8'h00, "toggle_reset_pad");
    frame("toggle_reset");

    tick(4);
    if (sb.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL scoreboard_drain: %0d left expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
